// File: rtl/bit_window_buffer_pkg.sv
// rtl/bit_window_buffer_pkg.sv - shared constants and state type for the bit window buffer
// Purpose: default geometry, the largest shift a consumer may request, and the
//          buffer state enumeration shared by the interface, merge and top.
// Ports:   none (package).
package bit_window_pkg;

    localparam int BW_WINDOW_BITS = 80;   // presented window width
    localparam int BW_STORE_BITS  = 128;  // bit store depth, multiple of 4
    localparam int BW_CNT_W       = 8;    // bit-count width, 2**CNT_W > STORE_BITS
    localparam int MAX_SHIFT      = 80;   // largest bitsToShift the consumer produces
    localparam int SHIFT_W        = 7;    // width of bitsToShift

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } bw_state_t;

endpackage

// File: rtl/bit_window_buffer_if.sv
// rtl/bit_window_buffer_if.sv - nibble input, window output and shift handshake bundle
// Purpose: groups the nibble stream, the presented window and the consumer shift
//          request into one bundle. Optional macro BIT_WINDOW_STATS_EN adds the
//          bitsConsumed / nibblesAccepted counters.
// Ports (slave = buffer side):
//   in : nibbleIn[3:0], nibbleValid, nibbleLast, shiftEn, bitsToShift[6:0]
//   out: nibbleReady, window[WINDOW_BITS-1:0], bitsAvail[CNT_W-1:0], windowValid,
//        shiftErr, streamDone, (stats) bitsConsumed[31:0], nibblesAccepted[15:0]
interface bit_window_buffer_if
    import bit_window_pkg::*;
#(
    parameter int WINDOW_BITS = BW_WINDOW_BITS,
    parameter int CNT_W       = BW_CNT_W
);
    logic [3:0]             nibbleIn;
    logic                   nibbleValid;
    logic                   nibbleLast;
    logic                   nibbleReady;
    logic [WINDOW_BITS-1:0] window;
    logic [CNT_W-1:0]       bitsAvail;
    logic                   windowValid;
    logic                   shiftEn;
    logic [SHIFT_W-1:0]     bitsToShift;
    logic                   shiftErr;
    logic                   streamDone;
`ifdef BIT_WINDOW_STATS_EN
    logic [31:0]            bitsConsumed;
    logic [15:0]            nibblesAccepted;

    modport master (
        output nibbleIn, nibbleValid, nibbleLast, shiftEn, bitsToShift,
        input  nibbleReady, window, bitsAvail, windowValid, shiftErr, streamDone,
        input  bitsConsumed, nibblesAccepted
    );
    modport slave (
        input  nibbleIn, nibbleValid, nibbleLast, shiftEn, bitsToShift,
        output nibbleReady, window, bitsAvail, windowValid, shiftErr, streamDone,
        output bitsConsumed, nibblesAccepted
    );
`else
    modport master (
        output nibbleIn, nibbleValid, nibbleLast, shiftEn, bitsToShift,
        input  nibbleReady, window, bitsAvail, windowValid, shiftErr, streamDone
    );
    modport slave (
        input  nibbleIn, nibbleValid, nibbleLast, shiftEn, bitsToShift,
        output nibbleReady, window, bitsAvail, windowValid, shiftErr, streamDone
    );
`endif
endinterface

// File: rtl/bit_window_buffer_merge.sv
// rtl/bit_window_buffer_merge.sv - combinational shift-out and nibble insert for the bit store
// Purpose: removes i_shift bits from the front of the MSB-aligned store and, when
//          i_accept is set, places i_nibble directly after the remaining bits.
// Ports:
//   i_store[STORE_BITS-1:0]  current store (bits below the valid region are 0)
//   i_bits_avail[CNT_W-1:0]  valid bits in i_store
//   i_shift[CNT_W-1:0]       bits removed this cycle (already legality-checked)
//   i_nibble[3:0], i_accept  nibble to append and its enable
//   o_store[STORE_BITS-1:0]  next store
module bit_window_merge #(
    parameter int STORE_BITS = 128,
    parameter int CNT_W      = 8
) (
    input  logic [STORE_BITS-1:0] i_store,
    input  logic [CNT_W-1:0]      i_bits_avail,
    input  logic [CNT_W-1:0]      i_shift,
    input  logic [3:0]            i_nibble,
    input  logic                  i_accept,
    output logic [STORE_BITS-1:0] o_store
);
    logic [CNT_W-1:0]      w_remain;
    logic [STORE_BITS-1:0] w_shifted;
    logic [STORE_BITS-1:0] w_nib_top;
    logic [STORE_BITS-1:0] w_insert;

    always_comb begin
        w_remain  = i_bits_avail - i_shift;
        // Zero fill from the left shift keeps everything below the valid region clear,
        // so the new nibble can simply be OR-ed into place.
        w_shifted = i_store << i_shift;
        w_nib_top = {i_nibble, {(STORE_BITS-4){1'b0}}};
        w_insert  = w_nib_top >> w_remain;
        o_store   = i_accept ? (w_shifted | w_insert) : w_shifted;
    end
endmodule

// File: rtl/bit_window_buffer.sv
// rtl/bit_window_buffer.sv - MSB-aligned nibble-to-bit window buffer for literal decode
// Purpose: collects hex nibbles into a bit store, presents the oldest WINDOW_BITS
//          bits to the consumer and drops consumed bits on request. Optional macro
//          BIT_WINDOW_STATS_EN adds bitsConsumed (saturating) and nibblesAccepted
//          (wrapping) counters.
// Ports:
//   clk     rising-edge clock
//   resetB  asynchronous active-low reset
//   bw      bit_window_buffer_if.slave (nibble stream, window, shift handshake)
module bit_window_buffer
    import bit_window_pkg::*;
#(
    parameter int WINDOW_BITS = BW_WINDOW_BITS,
    parameter int STORE_BITS  = BW_STORE_BITS,
    parameter int CNT_W       = BW_CNT_W
) (
    input  logic                  clk,
    input  logic                  resetB,
    bit_window_buffer_if.slave    bw
);
    bw_state_t             r_state;
    bw_state_t             w_state_next;
    logic [STORE_BITS-1:0] r_store;
    logic [STORE_BITS-1:0] w_store_next;
    logic [CNT_W-1:0]      r_bits_avail;
    logic [CNT_W-1:0]      w_bits_next;
    logic [CNT_W-1:0]      w_req;
    logic [CNT_W-1:0]      w_shift_amt;
    logic                  r_shift_err;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_legal;
    logic                  w_window_valid;

    // Ready comes only from registered state, so a same-cycle shift never raises it.
    always_comb begin
        w_ready = ((r_state == FILL) || (r_state == STREAM)) &&
                  (r_bits_avail <= CNT_W'(STORE_BITS - 4));
        w_accept = bw.nibbleValid & w_ready;

        w_window_valid = 1'b0;
        case (r_state)
            STREAM:  w_window_valid = 1'b1;
            DRAIN:   w_window_valid = (r_bits_avail != '0);
            default: w_window_valid = 1'b0;
        endcase

        w_req       = CNT_W'(bw.bitsToShift);
        w_legal     = bw.shiftEn & w_window_valid & (w_req <= r_bits_avail);
        w_shift_amt = w_legal ? w_req : '0;
        w_bits_next = r_bits_avail - w_shift_amt + (w_accept ? CNT_W'(4) : CNT_W'(0));
    end

    bit_window_merge #(
        .STORE_BITS (STORE_BITS),
        .CNT_W      (CNT_W)
    ) u_merge (
        .i_store      (r_store),
        .i_bits_avail (r_bits_avail),
        .i_shift      (w_shift_amt),
        .i_nibble     (bw.nibbleIn),
        .i_accept     (w_accept),
        .o_store      (w_store_next)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FILL: begin
                if (w_accept && bw.nibbleLast)
                    w_state_next = DRAIN;
                else if (w_bits_next >= CNT_W'(WINDOW_BITS))
                    w_state_next = STREAM;
            end
            STREAM: begin
                if (w_accept && bw.nibbleLast)
                    w_state_next = DRAIN;
                else if (w_bits_next < CNT_W'(WINDOW_BITS))
                    w_state_next = FILL;
            end
            DRAIN: begin
                if (w_bits_next == '0)
                    w_state_next = DONE;
            end
            default: w_state_next = DONE;
        endcase
    end

    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            r_state      <= FILL;
            r_store      <= '0;
            r_bits_avail <= '0;
            r_shift_err  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_store      <= w_store_next;
            r_bits_avail <= w_bits_next;
            // Any shift request the buffer cannot honour is latched until reset.
            if (bw.shiftEn && !w_legal)
                r_shift_err <= 1'b1;
        end
    end

`ifdef BIT_WINDOW_STATS_EN
    logic [31:0] r_bits_consumed;
    logic [15:0] r_nibbles_accepted;
    logic [32:0] w_consumed_sum;

    always_comb begin
        w_consumed_sum = {1'b0, r_bits_consumed} + 33'(w_shift_amt);
    end

    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            r_bits_consumed    <= '0;
            r_nibbles_accepted <= '0;
        end else begin
            if (w_legal)
                r_bits_consumed <= w_consumed_sum[32] ? 32'hFFFF_FFFF : w_consumed_sum[31:0];
            if (w_accept)
                r_nibbles_accepted <= r_nibbles_accepted + 16'd1;
        end
    end

    assign bw.bitsConsumed    = r_bits_consumed;
    assign bw.nibblesAccepted = r_nibbles_accepted;
`endif

    assign bw.window      = r_store[STORE_BITS-1 -: WINDOW_BITS];
    assign bw.bitsAvail   = r_bits_avail;
    assign bw.windowValid = w_window_valid;
    assign bw.nibbleReady = w_ready;
    assign bw.shiftErr    = r_shift_err;
    assign bw.streamDone  = (r_state == DONE);
endmodule

// File: tb/tb_bit_window_buffer.sv
// tb/tb_bit_window_buffer.sv - directed self-checking bench for bit_window_buffer
module tb_bit_window_buffer;
    import bit_window_pkg::*;

    logic clk = 1'b0;
    logic resetB;
    always #5 clk = ~clk;

    bit_window_buffer_if bw ();

    bit_window_buffer dut (
        .clk    (clk),
        .resetB (resetB),
        .bw     (bw.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] nib, input logic last);
        bw.nibbleIn    = nib;
        bw.nibbleValid = 1'b1;
        bw.nibbleLast  = last;
        tick();
        bw.nibbleValid = 1'b0;
        bw.nibbleLast  = 1'b0;
    endtask

    task automatic shift(input int n);
        bw.shiftEn     = 1'b1;
        bw.bitsToShift = 7'(n);
        tick();
        bw.shiftEn     = 1'b0;
        bw.bitsToShift = '0;
    endtask

    task automatic do_reset();
        resetB = 1'b0;
        tick();
        resetB = 1'b1;
        tick();
    endtask

    logic [79:0]  e_win;
    logic [127:0] m;
    logic [3:0]   lit [6];

    initial begin
        bw.nibbleIn    = '0;
        bw.nibbleValid = 1'b0;
        bw.nibbleLast  = 1'b0;
        bw.shiftEn     = 1'b0;
        bw.bitsToShift = '0;
        resetB         = 1'b0;
        lit[0] = 4'hD; lit[1] = 4'h2; lit[2] = 4'hF;
        lit[3] = 4'hE; lit[4] = 4'h2; lit[5] = 4'h8;
        #2;
        check_val("rst_bits_avail", 128'(bw.bitsAvail), 128'd0);
        check_val("rst_ready", 128'(bw.nibbleReady), 128'd1);
        check_val("rst_wvalid", 128'(bw.windowValid), 128'd0);
        check_val("rst_shift_err", 128'(bw.shiftErr), 128'd0);
        check_val("rst_done", 128'(bw.streamDone), 128'd0);
        check_val("rst_window", 128'(bw.window), 128'd0);
        tick();
        resetB = 1'b1;
        tick();

        // Literal packet D2FE28
        for (int i = 0; i < 6; i++) push(lit[i], i == 5);
        e_win = '0;
        e_win[79:56] = 24'hD2FE28;
        check_val("lit_bits_avail", 128'(bw.bitsAvail), 128'd24);
        check_val("lit_window", 128'(bw.window), 128'(e_win));
        check_val("lit_wvalid", 128'(bw.windowValid), 128'd1);
        check_val("lit_ready_drain", 128'(bw.nibbleReady), 128'd0);
        shift(6);
        e_win = '0;
        e_win[79:62] = 18'b101111111000101000;
        check_val("lit_sh6_bits", 128'(bw.bitsAvail), 128'd18);
        check_val("lit_sh6_window", 128'(bw.window), 128'(e_win));

        // Over-consume in DRAIN
        shift(8);
        e_win = '0;
        e_win[79:70] = 10'b1000101000;
        check_val("oc_bits10", 128'(bw.bitsAvail), 128'd10);
        check_val("oc_window10", 128'(bw.window), 128'(e_win));
        shift(11);
        check_val("oc_bits_hold", 128'(bw.bitsAvail), 128'd10);
        check_val("oc_err_set", 128'(bw.shiftErr), 128'd1);
        shift(4);
        e_win = '0;
        e_win[79:74] = 6'b101000;
        check_val("oc_bits6", 128'(bw.bitsAvail), 128'd6);
        check_val("oc_window6", 128'(bw.window), 128'(e_win));
        check_val("oc_err_sticky", 128'(bw.shiftErr), 128'd1);

        // Completion then asynchronous reset mid-cycle
        shift(6);
        check_val("done_flag", 128'(bw.streamDone), 128'd1);
        check_val("done_ready", 128'(bw.nibbleReady), 128'd0);
        check_val("done_wvalid", 128'(bw.windowValid), 128'd0);
        check_val("done_bits", 128'(bw.bitsAvail), 128'd0);
        #3;
        resetB = 1'b0;
        #1;
        check_val("arst_done", 128'(bw.streamDone), 128'd0);
        check_val("arst_ready", 128'(bw.nibbleReady), 128'd1);
        check_val("arst_err", 128'(bw.shiftErr), 128'd0);
        check_val("arst_bits", 128'(bw.bitsAvail), 128'd0);
        resetB = 1'b1;
        tick();

        // Backpressure at full store
        for (int i = 0; i < 32; i++) push(4'hF, 1'b0);
        check_val("bp_bits_full", 128'(bw.bitsAvail), 128'd128);
        check_val("bp_ready_full", 128'(bw.nibbleReady), 128'd0);
        check_val("bp_wvalid", 128'(bw.windowValid), 128'd1);
        push(4'h0, 1'b0);
        check_val("bp_no_accept", 128'(bw.bitsAvail), 128'd128);
        bw.nibbleIn    = 4'h5;
        bw.nibbleValid = 1'b1;
        bw.shiftEn     = 1'b1;
        bw.bitsToShift = 7'd80;
        #1;
        check_val("bp_ready_same_cycle", 128'(bw.nibbleReady), 128'd0);
        tick();
        bw.nibbleValid = 1'b0;
        bw.shiftEn     = 1'b0;
        bw.bitsToShift = '0;
        check_val("bp_bits_48", 128'(bw.bitsAvail), 128'd48);
        check_val("bp_ready_next", 128'(bw.nibbleReady), 128'd1);
        check_val("bp_wvalid_fill", 128'(bw.windowValid), 128'd0);
        check_val("bp_window", 128'(bw.window), 128'(80'hFFFF_FFFF_FFFF_0000_0000));

        // Simultaneous push and shift at 84 bits
        do_reset();
        m = '0;
        for (int i = 0; i < 21; i++) begin
            logic [31:0] iv;
            iv = 32'(i);
            m[127-4*i -: 4] = iv[3:0];
            push(iv[3:0], 1'b0);
        end
        check_val("sim_bits84", 128'(bw.bitsAvail), 128'd84);
        check_val("sim_wvalid", 128'(bw.windowValid), 128'd1);
        bw.nibbleIn    = 4'hA;
        bw.nibbleValid = 1'b1;
        bw.shiftEn     = 1'b1;
        bw.bitsToShift = 7'd3;
        tick();
        bw.nibbleValid = 1'b0;
        bw.shiftEn     = 1'b0;
        bw.bitsToShift = '0;
        m = m << 3;
        m[46:43] = 4'hA;
        check_val("sim_bits85", 128'(bw.bitsAvail), 128'd85);
        check_val("sim_window", 128'(bw.window), 128'(m[127:48]));
        shift(80);
        e_win = '0;
        e_win[79:75] = 5'b01010;
        check_val("sim_tail_bits", 128'(bw.bitsAvail), 128'd5);
        check_val("sim_tail_window", 128'(bw.window), 128'(e_win));
        check_val("sim_tail_wvalid", 128'(bw.windowValid), 128'd0);
        shift(1);
        check_val("sim_err_invalid", 128'(bw.shiftErr), 128'd1);
        check_val("sim_err_bits_hold", 128'(bw.bitsAvail), 128'd5);

`ifdef BIT_WINDOW_STATS_EN
        do_reset();
        check_val("st_rst_consumed", 128'(bw.bitsConsumed), 128'd0);
        for (int i = 0; i < 6; i++) push(lit[i], i == 5);
        shift(6);
        shift(15);
        shift(0);
        check_val("st_consumed", 128'(bw.bitsConsumed), 128'd21);
        check_val("st_nibbles", 128'(bw.nibblesAccepted), 128'd6);
        check_val("st_bits_left", 128'(bw.bitsAvail), 128'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
